// File: rtl/nios_mem_scrub_pkg.sv
// nios_mem_scrub_pkg
// Shared definitions for the memory scrub master: controller state encoding,
// command opcodes, default geometry of the on-chip memory slave and the
// slave's fixed read latency.
package nios_mem_scrub_pkg;

  localparam int DEF_ADDR_W   = 11;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_DEPTH    = 2048;
  localparam int READ_LATENCY = 1;

  localparam logic OP_FILL  = 1'b0;
  localparam logic OP_CHECK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // States in which a bus access is presented to the slave.
  function automatic logic is_bus_state(input state_t s);
    return (s == ST_FILL) || (s == ST_READ);
  endfunction

endpackage

// File: rtl/nios_mem_scrub_addr_gen.sv
// nios_mem_scrub_addr_gen
// Walks the word range of one command: holds the address and expected data of
// the access currently on the bus plus the count of words still to issue.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   i_load              latch base/length/pattern (command accepted)
//   i_step              advance to the next word
//   i_base, i_len       first address, clamped word count
//   i_pattern           seed data word
//   o_addr, o_exp       current address / expected data word
//   o_last              current word is the final one of the range
// Build option: MEM_SCRUB_INCR_PATTERN_EN makes expected(i) = pattern + i;
// without it every word expects the seed pattern.
module nios_mem_scrub_addr_gen #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W:0]   i_len,
  input  logic [DATA_W-1:0] i_pattern,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_exp,
  output logic              o_last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_exp;
  logic [ADDR_W:0]   r_rem;

  // Address and remaining-word counter; address wraps modulo DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr <= '0;
      r_rem  <= '0;
    end else if (i_load) begin
      r_addr <= i_base;
      r_rem  <= i_len;
    end else if (i_step) begin
      r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + ADDR_W'(1);
      r_rem  <= r_rem - (ADDR_W+1)'(1);
    end else begin
      r_addr <= r_addr;
      r_rem  <= r_rem;
    end
  end

  // Expected-data generator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_exp <= '0;
    end else if (i_load) begin
      r_exp <= i_pattern;
`ifdef MEM_SCRUB_INCR_PATTERN_EN
    end else if (i_step) begin
      r_exp <= r_exp + DATA_W'(1);
`endif
    end else begin
      r_exp <= r_exp;
    end
  end

  assign o_addr = r_addr;
  assign o_exp  = r_exp;
  assign o_last = (r_rem == (ADDR_W+1)'(1));

endmodule

// File: rtl/nios_mem_scrub_master.sv
// nios_mem_scrub_master
// Avalon-MM master for the on-chip memory's second slave port. A command
// either fills a word range with a pattern or reads it back and counts
// mismatches against the same pattern, recording the first failing address.
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   start, op, base_addr, length,      command (sampled only when idle);
//   pattern                            op 0 = FILL, 1 = CHECK
//   busy, done                         command in progress / completion pulse
//   err_count, first_err_addr          results of the last CHECK
//   avm_*                              master side of the memory slave port
// Build option: MEM_SCRUB_INCR_PATTERN_EN selects an incrementing pattern
// (expected(i) = pattern + i) instead of a constant fill.
module nios_mem_scrub_master
  import nios_mem_scrub_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] pattern,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic              avm_clken
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W:0]   w_len_clamped;
  logic              w_accept;
  logic              w_step;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_exp;

  logic              r_cs;
  logic              r_wr;
  logic [3:0]        r_be;
  logic              r_busy;
  logic              r_done;
  logic              r_clken;
  logic              r_cmp_vld;
  logic [DATA_W-1:0] r_cmp_exp;
  logic [ADDR_W-1:0] r_cmp_addr;
  logic [ADDR_W:0]   r_err_count;
  logic [ADDR_W-1:0] r_first_err;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_step   = is_bus_state(r_state);

  nios_mem_scrub_addr_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_addr_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load    (w_accept),
    .i_step    (w_step),
    .i_base    (base_addr),
    .i_len     (w_len_clamped),
    .i_pattern (pattern),
    .o_addr    (w_addr),
    .o_exp     (w_exp),
    .o_last    (w_last)
  );

  // Next-state logic; the word count is clamped to the memory depth.
  always_comb begin
    w_next_state  = r_state;
    w_len_clamped = (length > DEPTH_L) ? DEPTH_L : length;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_len_clamped == '0) begin
            w_next_state = ST_DONE;
          end else if (op == OP_CHECK) begin
            w_next_state = ST_READ;
          end else begin
            w_next_state = ST_FILL;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_FILL:  w_next_state = w_last ? ST_DONE : ST_FILL;
      ST_READ:  w_next_state = w_last ? ST_DRAIN : ST_READ;
      ST_DRAIN: w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // State register and registered bus/status strobes derived from next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cs    <= 1'b0;
      r_wr    <= 1'b0;
      r_be    <= 4'b0000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_clken <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cs    <= is_bus_state(w_next_state);
      r_wr    <= (w_next_state == ST_FILL);
      r_be    <= is_bus_state(w_next_state) ? 4'b1111 : 4'b0000;
      r_busy  <= is_bus_state(w_next_state) || (w_next_state == ST_DRAIN);
      r_done  <= (w_next_state == ST_DONE);
      r_clken <= 1'b1;
    end
  end

  // Read-compare pipeline: the expected word of a read is held one cycle so it
  // lines up with the slave's registered read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmp_vld  <= 1'b0;
      r_cmp_exp  <= '0;
      r_cmp_addr <= '0;
    end else begin
      r_cmp_vld  <= (r_state == ST_READ);
      r_cmp_exp  <= w_exp;
      r_cmp_addr <= w_addr;
    end
  end

  // Result registers: cleared on an accepted command, updated per mismatch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_count <= '0;
      r_first_err <= '0;
    end else if (w_accept) begin
      r_err_count <= '0;
      r_first_err <= '0;
    end else if (r_cmp_vld && (avm_readdata != r_cmp_exp)) begin
      r_err_count <= r_err_count + (ADDR_W+1)'(1);
      r_first_err <= (r_err_count == '0) ? r_cmp_addr : r_first_err;
    end else begin
      r_err_count <= r_err_count;
      r_first_err <= r_first_err;
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign err_count      = r_err_count;
  assign first_err_addr = r_first_err;
  assign avm_address    = w_addr;
  assign avm_byteenable = r_be;
  assign avm_chipselect = r_cs;
  assign avm_write      = r_wr;
  assign avm_writedata  = w_exp;
  assign avm_clken      = r_clken;

endmodule

// File: tb/tb_nios_mem_scrub_master.sv
// Testbench for nios_mem_scrub_master: table of commands against a model
// on-chip memory (1-cycle registered read, optional per-address corruption),
// plus hand-written reset sequences.
module tb_nios_mem_scrub_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [10:0] base_addr = 11'h000;
  logic [11:0] length = 12'h000;
  logic [31:0] pattern = 32'h0;
  logic        busy, done;
  logic [11:0] err_count;
  logic [10:0] first_err_addr;
  logic [10:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_chipselect, avm_write, avm_clken;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'h0;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [2048];
  logic        corrupt [2048];

  always #5 clk = ~clk;

  nios_mem_scrub_master dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .op             (op),
    .base_addr      (base_addr),
    .length         (length),
    .pattern        (pattern),
    .busy           (busy),
    .done           (done),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .avm_address    (avm_address),
    .avm_byteenable (avm_byteenable),
    .avm_chipselect (avm_chipselect),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .avm_clken      (avm_clken)
  );

  // Model memory slave: write on chipselect+write, registered read data.
  always @(posedge clk) begin
    if (avm_chipselect && avm_write && avm_clken)
      mem[avm_address] <= avm_writedata;
    avm_readdata <= mem[avm_address] ^ (corrupt[avm_address] ? 32'h0000_0001 : 32'h0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [31:0] pat, input int i);
`ifdef MEM_SCRUB_INCR_PATTERN_EN
    return pat + 32'(i);
`else
    return pat;
`endif
  endfunction

  typedef struct {
    logic        op;
    logic [10:0] base;
    logic [11:0] len;
    logic [31:0] pat;
    logic [11:0] corr_a;   // 12'hFFF = none
    logic [11:0] corr_b;
    logic        poke;     // pulse a different start while busy
    int          exp_done; // cycle after accepting edge where done=1
    int          exp_acc;
    logic [11:0] exp_err;
    logic [10:0] exp_first;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic run_cmd(input vec_t v, input int idx);
    int done_cyc = 0;
    int n_acc = 0;
    int seq_err = 0;
    int busy_err = 0;
    for (int a = 0; a < 2048; a++) corrupt[a] = 1'b0;
    if (v.corr_a != 12'hFFF) corrupt[v.corr_a[10:0]] = 1'b1;
    if (v.corr_b != 12'hFFF) corrupt[v.corr_b[10:0]] = 1'b1;
    @(negedge clk);
    start = 1'b1; op = v.op; base_addr = v.base; length = v.len; pattern = v.pat;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (v.poke && cyc == 2) begin
        start = 1'b1; op = ~v.op; base_addr = 11'h100; length = 12'd1; pattern = ~v.pat;
      end
      if (v.poke && cyc == 3) start = 1'b0;
      if (busy !== (cyc < v.exp_done)) busy_err++;
      if (avm_byteenable !== (avm_chipselect ? 4'b1111 : 4'b0000)) seq_err++;
      if (avm_chipselect) begin
        logic [10:0] ea;
        ea = v.base + 11'(n_acc);
        if (avm_address !== ea) seq_err++;
        if (avm_write !== (v.op == 1'b0)) seq_err++;
        if (avm_write && avm_writedata !== exp_data(v.pat, n_acc)) seq_err++;
        n_acc++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    check($sformatf("v%0d done_cycle", idx), done_cyc, v.exp_done);
    check($sformatf("v%0d access_count", idx), n_acc, v.exp_acc);
    check($sformatf("v%0d bus_sequence_errs", idx), seq_err, 0);
    check($sformatf("v%0d busy_errs", idx), busy_err, 0);
    check($sformatf("v%0d err_count", idx), {20'h0, err_count}, {20'h0, v.exp_err});
    check($sformatf("v%0d first_err_addr", idx), {21'h0, first_err_addr}, {21'h0, v.exp_first});
    @(negedge clk);
    check($sformatf("v%0d done_pulse_width", idx), {31'h0, done}, 32'h0);
  endtask

  initial begin
    vec_t post;
    for (int a = 0; a < 2048; a++) begin mem[a] = 32'h0; corrupt[a] = 1'b0; end
    //        op    base     len      pat           corr_a   corr_b   poke  done  acc  err     first
    vecs[0]  = '{1'b0, 11'h010, 12'd4,   32'hA5A50000, 12'hFFF, 12'hFFF, 1'b0, 5,    4,   12'd0, 11'h000};
    vecs[1]  = '{1'b1, 11'h010, 12'd4,   32'hA5A50000, 12'hFFF, 12'hFFF, 1'b0, 6,    4,   12'd0, 11'h000};
    vecs[2]  = '{1'b1, 11'h010, 12'd4,   32'hA5A50000, 12'h012, 12'hFFF, 1'b0, 6,    4,   12'd1, 11'h012};
    vecs[3]  = '{1'b1, 11'h010, 12'd4,   32'hA5A50000, 12'h011, 12'h013, 1'b0, 6,    4,   12'd2, 11'h011};
    vecs[4]  = '{1'b0, 11'h7FF, 12'd3,   32'h12345678, 12'hFFF, 12'hFFF, 1'b0, 4,    3,   12'd0, 11'h000};
    vecs[5]  = '{1'b1, 11'h7FF, 12'd3,   32'h12345678, 12'hFFF, 12'hFFF, 1'b0, 5,    3,   12'd0, 11'h000};
    vecs[6]  = '{1'b1, 11'h7FF, 12'd3,   32'h12345679, 12'hFFF, 12'hFFF, 1'b0, 5,    3,   12'd3, 11'h7FF};
    vecs[7]  = '{1'b0, 11'h050, 12'd0,   32'hFFFFFFFF, 12'hFFF, 12'hFFF, 1'b0, 1,    0,   12'd0, 11'h000};
    vecs[8]  = '{1'b0, 11'h020, 12'd4,   32'hDEADBEEF, 12'hFFF, 12'hFFF, 1'b1, 5,    4,   12'd0, 11'h000};
    vecs[9]  = '{1'b1, 11'h020, 12'd4,   32'hDEADBEEF, 12'hFFF, 12'hFFF, 1'b1, 6,    4,   12'd0, 11'h000};
    vecs[10] = '{1'b0, 11'h100, 12'hFFF, 32'h00000000, 12'hFFF, 12'hFFF, 1'b0, 2049, 2048, 12'd0, 11'h000};
    vecs[11] = '{1'b1, 11'h100, 12'hFFF, 32'h00000000, 12'h0FF, 12'hFFF, 1'b0, 2050, 2048, 12'd1, 11'h0FF};

    // Reset state.
    #12;
    check("rst_chipselect", {31'h0, avm_chipselect}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_clken", {31'h0, avm_clken}, 32'h0);
    check("rst_err_count", {20'h0, err_count}, 32'h0);
    check("rst_byteenable", {28'h0, avm_byteenable}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("clken_after_release", {31'h0, avm_clken}, 32'h1);

    for (int i = 0; i < NV; i++) run_cmd(vecs[i], i);

    // Reset in the middle of a CHECK that has already seen one mismatch.
    for (int a = 0; a < 2048; a++) corrupt[a] = 1'b0;
    corrupt[11'h100] = 1'b1;
    @(negedge clk);
    start = 1'b1; op = 1'b1; base_addr = 11'h100; length = 12'd8; pattern = 32'h0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_err_before", {20'h0, err_count}, 32'h1);
    check("midrst_busy_before", {31'h0, busy}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_chipselect", {31'h0, avm_chipselect}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_err_count", {20'h0, err_count}, 32'h0);
    check("midrst_clken", {31'h0, avm_clken}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_clken_release", {31'h0, avm_clken}, 32'h1);
    post = vecs[0];
    run_cmd(post, 100);
    post = vecs[2];
    run_cmd(post, 101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
